// File: rtl/led_pattern_gen.sv
// LED pattern engine: a programmable prescaler steps one of several patterns
// (rotate, bounce, count, blink, fill) and drives an active-low LED bank.
module led_pattern_gen #(
  parameter int WIDTH          = 32,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 25_000_000
) (
  input  logic             clk_in,
  input  logic             sys_rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             pause,
  input  logic             step,
  output logic             tick,
  output logic [WIDTH-1:0] led_light
);

  typedef enum logic [2:0] {
    MODE_ROT_L  = 3'd0,
    MODE_ROT_R  = 3'd1,
    MODE_BOUNCE = 3'd2,
    MODE_COUNT  = 3'd3,
    MODE_BLINK  = 3'd4,
    MODE_FILL   = 3'd5,
    MODE_RSVD6  = 3'd6,
    MODE_RSVD7  = 3'd7
  } mode_e;

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] eff_period;
  logic             wrap;
  logic             adv;

  function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      MODE_ROT_L, MODE_BOUNCE: s = WIDTH'(1);
      MODE_ROT_R:              s = {1'b1, {(WIDTH-1){1'b0}}};
      default:                 s = '0;
    endcase
    return s;
  endfunction

  always_comb begin
    // A programmed period of zero runs as if it were one.
    eff_period = (period_q == '0) ? CNT_W'(1) : period_q;
    wrap       = (cnt_q == eff_period - CNT_W'(1));
    adv        = (~pause & wrap) | (pause & step);

    mode_d   = mode_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    dir_d    = dir_q;
    tick_d   = 1'b0;

    if (cfg_we) begin
      mode_d   = mode_e'(cfg_mode);
      period_d = cfg_period;
      cnt_d    = '0;
      pat_d    = seed_of(mode_e'(cfg_mode));
      dir_d    = 1'b0;
    end else begin
      if (!pause) begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      tick_d = adv;
      if (adv) begin
        case (mode_q)
          MODE_ROT_L: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
          MODE_ROT_R: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
          MODE_BOUNCE: begin
            // Direction turns on the same edge the lit bit reaches an end.
            if (!dir_q) begin
              pat_d = pat_q << 1;
              dir_d = pat_d[WIDTH-1];
            end else begin
              pat_d = pat_q >> 1;
              dir_d = ~pat_d[0];
            end
          end
          MODE_COUNT: pat_d = pat_q + WIDTH'(1);
          MODE_BLINK: pat_d = ~pat_q;
          MODE_FILL:  pat_d = (&pat_q) ? '0 : {pat_q[WIDTH-2:0], 1'b1};
          default:    pat_d = pat_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      mode_q   <= MODE_ROT_L;
      period_q <= CNT_W'(DEFAULT_PERIOD);
      cnt_q    <= '0;
      pat_q    <= WIDTH'(1);
      dir_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      dir_q    <= dir_d;
      tick_q   <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign led_light = ~pat_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: 8-bit and 4-bit instances share stimulus and are
// compared every cycle against a step-count based pattern model.
module tb_led_pattern_gen;

  localparam int CW   = 16;
  localparam int DEFP = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_mode = '0;
  logic [CW-1:0] cfg_period = '0;
  logic          pause = 1'b0;
  logic          step = 1'b0;
  logic          tick8, tick4;
  logic [7:0]    led8;
  logic [3:0]    led4;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state: mode, period, non-paused cycles since seed, steps taken.
  int          m_mode;
  int unsigned m_period;
  int unsigned m_elapsed;
  int unsigned m_steps;
  logic        m_tick;

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(8), .CNT_W(CW), .DEFAULT_PERIOD(DEFP)) u_dut8 (
    .clk_in(clk), .sys_rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .pause(pause), .step(step),
    .tick(tick8), .led_light(led8)
  );

  led_pattern_gen #(.WIDTH(4), .CNT_W(CW), .DEFAULT_PERIOD(DEFP)) u_dut4 (
    .clk_in(clk), .sys_rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .pause(pause), .step(step),
    .tick(tick4), .led_light(led4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Pattern after n steps from the seed of a mode, for an LED bank of w bits.
  function automatic logic [31:0] exp_pat(input int mode, input int unsigned n, input int w);
    longint unsigned full, p;
    int unsigned     k;
    full = (64'd1 << w) - 1;
    case (mode)
      0: p = 64'd1 << (n % w);
      1: p = 64'd1 << (w - 1 - (n % w));
      2: begin
        k = n % (2 * w - 2);
        p = (k < w) ? (64'd1 << k) : (64'd1 << (2 * w - 2 - k));
      end
      3: p = n % (64'd1 << w);
      4: p = (n % 2 == 1) ? full : 64'd0;
      5: p = (64'd1 << (n % (w + 1))) - 1;
      default: p = 64'd0;
    endcase
    return 32'(p & full);
  endfunction

  task automatic model_step();
    int unsigned pe;
    logic        adv;
    if (rst) begin
      m_mode = 0; m_period = DEFP; m_elapsed = 0; m_steps = 0; m_tick = 1'b0;
    end else if (cfg_we) begin
      m_mode = int'(cfg_mode); m_period = cfg_period;
      m_elapsed = 0; m_steps = 0; m_tick = 1'b0;
    end else begin
      pe  = (m_period == 0) ? 1 : m_period;
      adv = 1'b0;
      if (!pause) begin
        m_elapsed++;
        adv = (m_elapsed % pe == 0);
      end else begin
        adv = step;
      end
      if (adv) m_steps++;
      m_tick = adv;
    end
  endtask

  task automatic run_cycle();
    model_step();
    @(posedge clk);
    #1;
    check_eq("led8",  {24'b0, led8},  ~exp_pat(m_mode, m_steps, 8) & 32'hFF);
    check_eq("tick8", {31'b0, tick8}, {31'b0, m_tick});
    check_eq("led4",  {28'b0, led4},  ~exp_pat(m_mode, m_steps, 4) & 32'hF);
    check_eq("tick4", {31'b0, tick4}, {31'b0, m_tick});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_cfg(input int mode, input int period);
    cfg_we = 1'b1; cfg_mode = 3'(mode); cfg_period = CW'(period);
    run_cycle();
    cfg_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pause_ticks;

    // Reset, then default-period stepping straight out of reset.
    rst = 1'b1;
    run(2);
    check_eq("rst_led8", {24'b0, led8}, 32'hFE);
    rst = 1'b0;
    run(22);

    // Rotate left, period 4: wraps 80 -> 01 within the run.
    do_cfg(0, 4);
    run(40);
    do_cfg(2, 1);
    run(20);
    do_cfg(3, 2);
    run(530);
    do_cfg(5, 0);
    run(20);
    do_cfg(1, 3);
    run(30);
    do_cfg(4, 2);
    run(10);
    do_cfg(6, 1);
    run(5);
    do_cfg(7, 2);
    run(5);

    // Pause at cnt=6 with a period of 10, two single-cycle steps inside.
    do_cfg(0, 10);
    run(6);
    pause = 1'b1;
    pause_ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step = (i == 5 || i == 12);
      run_cycle();
      if (tick8) pause_ticks++;
    end
    step = 1'b0;
    check_eq("pause_ticks", 32'(pause_ticks), 32'd2);
    pause = 1'b0;
    run(15);

    // Step held high while paused advances every cycle.
    pause = 1'b1; step = 1'b1;
    run(6);
    // cfg_we colliding with a step: seed wins, no tick.
    do_cfg(2, 1);
    step = 1'b0; pause = 1'b0;
    run(3);
    // cfg_we colliding with a wrap (period 1 wraps every cycle).
    do_cfg(5, 1);
    run(4);

    // Reset mid-count restores mode and period too.
    do_cfg(3, 3);
    run(7);
    rst = 1'b1;
    run_cycle();
    check_eq("rst_mid_led8", {24'b0, led8}, 32'hFE);
    rst = 1'b0;
    run(12);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      cfg_we     = ($urandom_range(0, 29) == 0);
      cfg_mode   = 3'($urandom_range(0, 7));
      cfg_period = CW'($urandom_range(0, 5));
      pause      = ($urandom_range(0, 5) == 0) ? ~pause : pause;
      step       = ($urandom_range(0, 2) == 0);
      run_cycle();
    end
    rst = 1'b0; cfg_we = 1'b0; pause = 1'b0; step = 1'b0;
    run(4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the board LED bank. A programmable-period prescaler advances one of several selectable patterns: rotate left/right, bounce, binary count, blink, fill. It adds pause and single-step control, and emits a step-tick pulse for other board logic. It sits directly on the board clock and drives the LED pins, which are active-low.

## Interface
- WIDTH, 32, number of LEDs; legal range 2..32
- CNT_W, 32, width of the period register and prescaler counter
- DEFAULT_PERIOD, 25_000_000, prescaler period loaded at reset, in clk_in cycles
- clk_in  input  1  board clock; all state updates on its rising edge
- sys_rst  input  1  synchronous, active-high reset
- cfg_we  input  1  one-cycle strobe; loads cfg_mode and cfg_period
- cfg_mode  input  3  pattern select, sampled only when cfg_we=1
- cfg_period  input  CNT_W  step period in cycles, sampled only when cfg_we=1
- pause  input  1  level; freezes the prescaler while high
- step  input  1  advances the pattern by one step when pause=1; ignored when pause=0
- tick  output  1  registered; high for exactly the one cycle in which a newly advanced pattern is first visible
- led_light  output  WIDTH  active-low LED drive, equal to ~pat

## Operation
- Registers:
  - mode_q[2:0]
  - period_q[CNT_W-1:0]
  - cnt[CNT_W-1:0]
  - pat[WIDTH-1:0]
  - dir: 0 = left, 1 = right
  - tick
- Reset (sys_rst=1):
  - mode_q=0, period_q=DEFAULT_PERIOD, cnt=0, pat=1, dir=0, tick=0
  - led_light therefore resets to ~1 (only LED0 lit).
- Effective period: Pe = max(period_q, 1). A period of 0 behaves as 1.
- wrap = (cnt == Pe-1).
- adv = (~pause & wrap) | (pause & step).
- Prescaler:
  - pause=0: cnt <= wrap ? 0 : cnt+1
  - pause=1: cnt holds.
- Pattern step on adv, by mode_q (seed = pat value loaded on cfg_we):
  - 0 ROT_L: seed 1; pat <= {pat[W-2:0], pat[W-1]}
  - 1 ROT_R: seed 1<<(W-1); pat <= {pat[0], pat[W-1:1]}
  - 2 BOUNCE: seed 1, dir=0.
    - dir=0: pat <= pat<<1; if the new pat[W-1]=1, dir <= 1 at the same edge.
    - dir=1: pat <= pat>>1; if the new pat[0]=1, dir <= 0.
    - Cycle length is 2W-2 steps.
  - 3 COUNT: seed 0; pat <= pat+1, modulo 2^WIDTH (wraps from all-ones to 0).
  - 4 BLINK: seed 0; pat <= ~pat
  - 5 FILL: seed 0; if pat is all-ones then pat <= 0, else pat <= {pat[W-2:0], 1'b1}
  - 6, 7 reserved: seed 0; pat holds, but tick still pulses on adv.
- tick <= adv. Register it at the same edge that updates pat.
- Priority, highest first: sys_rst > cfg_we > adv.
- On cfg_we:
  - mode_q <= cfg_mode, period_q <= cfg_period, cnt <= 0
  - pat <= seed(cfg_mode), dir <= 0, tick <= 0
  - Any adv, pause or step in that cycle is discarded.
- pause asserted mid-count: cnt keeps its value. On deassert, counting resumes from that value; it is not restarted.
- pause=1 with step held high: the pattern advances every cycle.

## Timing
- Count rising edges with sys_rst=0 and no cfg_we, starting from reset release.
  - The first pattern advance happens at edge Pe.
  - Subsequent advances happen at edges k·Pe.
  - tick is high in the cycle following each of those edges.
- cfg_we at edge E: the new seed is visible after E. The first advance is at E+Pe_new.
- Step latency: step high at edge E (with pause=1) makes the new pat and tick=1 visible after E.
- Pe=1: pattern advances every edge and tick stays high continuously.
- sys_rst mid-operation: all state returns to reset values at the next edge, including mode_q and period_q.
- No combinational path from any input to any output.

## Test plan
- WIDTH=8, reset, then cfg_we with mode=0, period=4:
  - led_light=8'hFE right after reset, 8'hFD after edge 4 with tick=1 for one cycle.
  - Rotation wraps 8'h80 -> 8'h01 on pat.
- mode=2, period=1, WIDTH=8:
  - pat sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02.
  - dir flips exactly at 80 and 01.
- mode=3, period=2, WIDTH=4: pat counts 0..F then wraps to 0; one tick every 2 cycles.
- mode=5 with period=0, WIDTH=4: 0,1,3,7,F,0 on consecutive edges (period 0 treated as 1).
- period=10, pause asserted at cnt=6 for 20 cycles with two single-cycle step pulses:
  - Exactly two advances and two tick pulses occur during the pause.
  - After release, the next advance comes 4 cycles later.
- cfg_we and step/wrap in the same cycle: seed is loaded, no advance, tick=0. sys_rst asserted mid-count: all outputs reach reset values after one edge.
